// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding,
// datapath widths and the default abort timeout.
package mem_stage_pkg;

  localparam int unsigned XLEN               = 64;
  localparam int unsigned REG_ADDR_W         = 5;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

endpackage : mem_stage_pkg

// File: rtl/mem_timeout_ctr.sv
// WAIT-cycle counter for the MEM stage abort timeout.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,   // entering WAIT
  input  logic inc_i,     // WAIT cycle with no memory completion
  output logic expire_o   // counter has reached its last allowed value
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clearing on WAIT entry wins over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule : mem_timeout_ctr

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues registered data-memory requests, stalls the
// front of the pipeline while a request is outstanding, and loads MEM/WB.
// Optional feature macro: MEM_TIMEOUT_EN (abort a request after
// TIMEOUT_CYCLES WAIT cycles and pulse mem_error).
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  RegWrite_MEM,
  input  logic                  MemtoReg_MEM,
  input  logic                  MemRead_MEM,
  input  logic                  MemWrite_MEM,
  input  logic [XLEN-1:0]       ALUResult_MEM,
  input  logic [XLEN-1:0]       write_data_MEM,
  input  logic [REG_ADDR_W-1:0] rd_MEM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [XLEN-1:0]       dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  input  logic                  dmem_ready,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  stall_MEM,
  output logic                  RegWrite_WB,
  output logic                  MemtoReg_WB,
  output logic [XLEN-1:0]       ALUResult_WB,
  output logic [XLEN-1:0]       read_data_WB,
  output logic [REG_ADDR_W-1:0] rd_WB,
  output logic                  mem_error
);

  mem_state_e state_q, state_d;

  logic access;
  logic issue;        // IDLE -> WAIT, launch request
  logic complete;     // WAIT with dmem_ready
  logic abort;        // WAIT timed out
  logic capture;      // MEM/WB takes the EX/MEM fields this edge
  logic timeout_hit;

  logic                  dmem_req_q, dmem_we_q;
  logic [XLEN-1:0]       dmem_addr_q, dmem_wdata_q;
  logic                  regwrite_wb_q, memtoreg_wb_q;
  logic [XLEN-1:0]       alu_wb_q, rdata_wb_q;
  logic [REG_ADDR_W-1:0] rd_wb_q;

  assign access = MemRead_MEM | MemWrite_MEM;

`ifdef MEM_TIMEOUT_EN
  logic ctr_expire;
  logic mem_error_q;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (issue),
    .inc_i    ((state_q == ST_WAIT) && !dmem_ready),
    .expire_o (ctr_expire)
  );

  assign timeout_hit = (state_q == ST_WAIT) && !dmem_ready && ctr_expire;

  // One-cycle error pulse on the edge that abandons a timed-out request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_error_q <= 1'b0;
    end else begin
      mem_error_q <= abort;
    end
  end

  assign mem_error = mem_error_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_error   = 1'b0;
`endif

  // FSM next state and stage control; dmem_ready in IDLE is ignored.
  always_comb begin
    state_d   = state_q;
    stall_MEM = 1'b0;
    issue     = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (access) begin
          stall_MEM = 1'b1;
          issue     = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          capture   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          complete = 1'b1;
          capture  = 1'b1;
          state_d  = ST_IDLE;
        end else if (timeout_hit) begin
          abort    = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          stall_MEM = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory request registers; address/data/we hold for the whole request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else if (issue) begin
      dmem_req_q   <= 1'b1;
      dmem_we_q    <= MemWrite_MEM;
      dmem_addr_q  <= ALUResult_MEM;
      dmem_wdata_q <= write_data_MEM;
    end else if (complete || abort) begin
      dmem_req_q   <= 1'b0;
    end
  end

  // MEM/WB register; EX/MEM is held by the stall, so its fields are still
  // valid at completion. Non-capture edges insert a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_wb_q <= 1'b0;
      memtoreg_wb_q <= 1'b0;
      alu_wb_q      <= '0;
      rdata_wb_q    <= '0;
      rd_wb_q       <= '0;
    end else if (capture) begin
      regwrite_wb_q <= RegWrite_MEM && (rd_MEM != '0);
      memtoreg_wb_q <= MemtoReg_MEM;
      alu_wb_q      <= ALUResult_MEM;
      rd_wb_q       <= rd_MEM;
      if (complete && !dmem_we_q) begin
        rdata_wb_q  <= dmem_rdata;
      end
    end else begin
      regwrite_wb_q <= 1'b0;
      memtoreg_wb_q <= 1'b0;
    end
  end

  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign RegWrite_WB  = regwrite_wb_q;
  assign MemtoReg_WB  = memtoreg_wb_q;
  assign ALUResult_WB = alu_wb_q;
  assign read_data_WB = rdata_wb_q;
  assign rd_WB        = rd_wb_q;

endmodule : mem_access_stage
